// File: rtl/cache_loader_pkg.sv
// Shared constants and FSM state encoding for the boot-time CACHE loader.
// The checksum states are always encoded; they are only reachable with CACHE_LOADER_CHECKSUM_EN.
package cache_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 2;
  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DEFAULT_DATA_W = 16;

  typedef enum logic [3:0] {
    StIdle,
    StCntHi,
    StCntLo,
    StDatHi,
    StDatLo,
    StWr,
    StDone,
    StErr,
    StCkHi,
    StCkLo
  } state_e;

endpackage

// File: rtl/cache_loader_byte_assembler.sv
// Collects host bytes into a word, high byte first; word_valid pulses on the final byte transfer.
// word is combinational so the caller can register it on the same edge as the last byte.
module cache_loader_byte_assembler
  import cache_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          Reset,
  input  logic                          clear,
  input  logic                          xfer,
  input  logic [7:0]                    data,
  output logic                          word_valid,
  output logic [8*BYTES_PER_WORD-1:0]   word
);

  localparam int unsigned PrevW = 8 * (BYTES_PER_WORD - 1);
  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES_PER_WORD - 1);

  logic [PrevW-1:0] prev_q, prev_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  assign word       = {prev_q, data};
  assign word_valid = xfer && (cnt_q == LastCnt);

  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (xfer) begin
      prev_d = PrevW'({prev_q, data});
      cnt_d  = word_valid ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_loader.sv
// Boot loader: receives a word count and image over a byte handshake, writes it into CACHE,
// then releases the CPU. Define CACHE_LOADER_CHECKSUM_EN to require a trailing 16-bit checksum.
module cache_loader
  import cache_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InValid,
  input  logic [7:0]        InData,
  output logic              InReady,
  output logic              Write,
  output logic [ADDR_W-1:0] Waddr,
  output logic [DATA_W-1:0] Wdata,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic              CpuHold
);

  localparam int unsigned WordW    = 8 * BYTES_PER_WORD;
  localparam int unsigned MaxWords = (1 << ADDR_W) - BASE_ADDR;

`ifdef CACHE_LOADER_CHECKSUM_EN
  localparam state_e StFinish = StCkHi;
  logic [WordW-1:0] sum_q, sum_d;
`else
  localparam state_e StFinish = StDone;
`endif

  state_e            state_q, state_d;
  logic [WordW-1:0]  count_q, count_d;
  logic [WordW-1:0]  index_q, index_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic             xfer, asm_clear, word_valid;
  logic [WordW-1:0] word;

  assign xfer    = InValid & InReady;
  assign Write   = write_q;
  assign Waddr   = waddr_q;
  assign Wdata   = wdata_q;

  cache_loader_byte_assembler u_asm (
    .clk        (clk),
    .Reset      (Reset),
    .clear      (asm_clear),
    .xfer       (xfer),
    .data       (InData),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    index_d   = index_q;
    write_d   = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
`ifdef CACHE_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (Start) begin
          state_d   = StCntHi;
          asm_clear = 1'b1;
`ifdef CACHE_LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      StCntHi: if (xfer) state_d = StCntLo;
      StCntLo: begin
        if (word_valid) begin
          count_d = word;
          index_d = '0;
          if (word == '0) begin
            state_d = StFinish;
          end else if (32'(word) > MaxWords) begin
            state_d = StErr;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: if (xfer) state_d = StDatLo;
      StDatLo: begin
        if (word_valid) begin
          state_d = StWr;
          write_d = 1'b1;
          waddr_d = ADDR_W'(BASE_ADDR + 32'(index_q));
          wdata_d = DATA_W'(word);
`ifdef CACHE_LOADER_CHECKSUM_EN
          sum_d   = sum_q + word;
`endif
        end
      end
      StWr: begin
        index_d = index_q + WordW'(1);
        state_d = (index_q + WordW'(1) == count_q) ? StFinish : StDatHi;
      end
`ifdef CACHE_LOADER_CHECKSUM_EN
      StCkHi: if (xfer) state_d = StCkLo;
      StCkLo: if (word_valid) state_d = (word == sum_q) ? StDone : StErr;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Status and handshake outputs decode directly from the registered state.
  always_comb begin
    InReady = 1'b0;
    Busy    = 1'b0;
    unique case (state_q)
      StCntHi, StCntLo, StDatHi, StDatLo, StCkHi, StCkLo: begin
        InReady = 1'b1;
        Busy    = 1'b1;
      end
      StWr:    Busy = 1'b1;
      default: ;
    endcase
    Done    = (state_q == StDone);
    Error   = (state_q == StErr);
    CpuHold = (state_q != StDone);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      count_q <= '0;
      index_q <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef CACHE_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      write_q <= write_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef CACHE_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_loader.sv
// Randomized bench for cache_loader: a load-level model predicts writes and final status.
// Honours CACHE_LOADER_CHECKSUM_EN the same way as the design.
module tb_cache_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned Cap       = (1 << ADDR_W) - BASE_ADDR;

  logic              clk = 1'b0;
  logic              Reset, Start, InValid;
  logic [7:0]        InData;
  logic              InReady, Write, Busy, Done, Error, CpuHold;
  logic [ADDR_W-1:0] Waddr;
  logic [DATA_W-1:0] Wdata;

  always #5 clk = ~clk;

  cache_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk     (clk),
    .Reset   (Reset),
    .Start   (Start),
    .InValid (InValid),
    .InData  (InData),
    .InReady (InReady),
    .Write   (Write),
    .Waddr   (Waddr),
    .Wdata   (Wdata),
    .Busy    (Busy),
    .Done    (Done),
    .Error   (Error),
    .CpuHold (CpuHold)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] img[$];
  logic [31:0] exp_wr[$];
  logic [31:0] wr_log[$];
  int          stall_mode = 0;
  bit          tog = 1'b0;
  bit          abort = 1'b0;

  // Every write cycle is logged; the loader must never accept a byte while writing.
  always @(negedge clk) begin
    if (Write === 1'b1) begin
      wr_log.push_back(32'({Waddr, Wdata}));
      check("inready_in_wr", 32'(InReady), 32'd0);
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_write"}, 32'(Write), 32'd0);
    check({tag, "_inready"}, 32'(InReady), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_error"}, 32'(Error), 32'd0);
    check({tag, "_cpuhold"}, 32'(CpuHold), 32'd1);
    check({tag, "_waddr"}, 32'(Waddr), 32'd0);
    check({tag, "_wdata"}, 32'(Wdata), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit taken = 1'b0;
    int t = 0;
    if (abort) return;
    while (!taken) begin
      @(negedge clk);
      case (stall_mode)
        0:       InValid = 1'b1;
        1:       begin InValid = tog; tog = ~tog; end
        default: InValid = 1'($urandom_range(0, 1));
      endcase
      InData = InValid ? b : 8'($urandom);
      taken  = InValid && InReady;
      t++;
      if (!taken && t > 100) begin
        check("byte_timeout", 32'd0, 32'd1);
        abort = 1'b1;
        InValid = 1'b0;
        return;
      end
    end
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    InValid = 1'b0;
    Start   = 1'b1;
    wr_log.delete();
    @(posedge clk);
    #1;
    check({tag, "_start_busy"}, 32'(Busy), 32'd1);
    check({tag, "_start_cpuhold"}, 32'(CpuHold), 32'd1);
    check({tag, "_start_flags"}, 32'({Done, Error}), 32'd0);
    Start = 1'b0;
  endtask

  // A Start pulse in the middle of a load must be ignored.
  task automatic glitch_start(input string tag);
    @(negedge clk);
    InValid = 1'b0;
    Start   = 1'b1;
    @(negedge clk);
    Start   = 1'b0;
    check({tag, "_glitch_busy"}, 32'(Busy), 32'd1);
  endtask

  task automatic run_load(input string tag, input int n, input bit corrupt, input bit glitch);
    bit          exp_err;
    logic [15:0] sum = 16'h0;
    logic [15:0] ck;
    int          t;
    exp_wr.delete();
    exp_err = (n > int'(Cap));
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back(32'({ADDR_W'(BASE_ADDR + i), img[i]}));
        sum = sum + img[i];
      end
    end
    ck = sum ^ (corrupt ? 16'h0001 : 16'h0000);
    $display("load %s n=%0d checksum=%04h stall=%0d", tag, n, ck, stall_mode);
`ifdef CACHE_LOADER_CHECKSUM_EN
    if (!exp_err && corrupt) exp_err = 1'b1;
`endif
    pulse_start(tag);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    if (n <= int'(Cap)) begin
      for (int i = 0; i < n; i++) begin
        send_byte(img[i][15:8]);
        send_byte(img[i][7:0]);
        if (glitch && i == 0 && !abort) glitch_start(tag);
      end
`ifdef CACHE_LOADER_CHECKSUM_EN
      send_byte(ck[15:8]);
      send_byte(ck[7:0]);
`endif
    end
    t = 0;
    do begin
      @(negedge clk);
      InValid = 1'b0;
      t++;
    end while (!(Done || Error) && t < 40);
    check({tag, "_finished"}, 32'(Done || Error), 32'd1);
    check({tag, "_done"}, 32'(Done), 32'(!exp_err));
    check({tag, "_error"}, 32'(Error), 32'(exp_err));
    check({tag, "_cpuhold"}, 32'(CpuHold), 32'(exp_err));
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_nwrites"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check({tag, "_wr"}, wr_log[i], exp_wr[i]);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(16'($urandom));
  endtask

  initial begin
    int t;
    int n;
    Reset   = 1'b1;
    Start   = 1'b0;
    InValid = 1'b0;
    InData  = 8'h00;
    #12;
    check_reset("por");
    @(negedge clk);
    Reset = 1'b0;

    // Three-word image, no stalls, then with InValid toggling.
    img = '{16'h1234, 16'hABCD, 16'h0001};
    stall_mode = 0;
    run_load("s1", 3, 1'b0, 1'b0);
    stall_mode = 1;
    run_load("s1_stall", 3, 1'b0, 1'b0);
`ifdef CACHE_LOADER_CHECKSUM_EN
    stall_mode = 0;
    run_load("s1_badck", 3, 1'b1, 1'b0);
`endif

    // Count boundaries.
    stall_mode = 0;
    img.delete();
    run_load("n0", 0, 1'b0, 1'b0);
    run_load("n1025", 1025, 1'b0, 1'b0);
    rand_img(1024);
    run_load("n1024", 1024, 1'b0, 1'b0);
    check("n1024_last_waddr", 32'(Waddr), 32'h3FF);

    // Asynchronous reset right after the second word is written.
    pulse_start("rst");
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h22);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!(Write === 1'b1 && Waddr == 10'd1) && t < 10);
    check("rst_second_write", 32'({Write, Waddr, Wdata}), 32'({1'b1, 10'd1, 16'h2222}));
    #2;
    Reset   = 1'b1;
    InValid = 1'b0;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    Reset = 1'b0;
    img = '{16'hBEEF};
    run_load("after_rst", 1, 1'b0, 1'b0);

    // Start during a load is ignored; back-to-back loads exercise reload from Done.
    rand_img(4);
    stall_mode = 2;
    run_load("glitch", 4, 1'b0, 1'b1);
    rand_img(2);
    run_load("reload", 2, 1'b0, 1'b0);

    // Randomized loads, counts around the limits included.
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 5))
        0:       n = int'(Cap) + 1 + int'($urandom_range(0, 3000));
        1:       n = 0;
        default: n = int'($urandom_range(1, 12));
      endcase
      rand_img((n <= int'(Cap)) ? n : 0);
      stall_mode = int'($urandom_range(0, 2));
      run_load("rand", n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0) && n > 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_loader.md
Name: cache_loader

Overview:
- Boot-time writer for the 1024x16 CACHE data/instruction store.
- Accepts a byte stream from a host link with a valid/ready handshake and assembles 16-bit words, high byte first.
- Writes the words sequentially into CACHE through its Write/Waddr/Wdata port.
- Holds the CPU core in reset until the image is fully loaded, then releases it.

Parameters:
- ADDR_W, 10, CACHE address width; capacity is 2^ADDR_W words.
- DATA_W, 16, CACHE word width; fixed at 2 bytes per word.
- BASE_ADDR, 0, first CACHE address written.

Ports:
- clk  in  1  clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse that begins a load.
- InValid  in  1  host byte valid.
- InData  in  8  host byte.
- InReady  out  1  loader can accept a byte; a byte transfers when InValid && InReady on a clk edge.
- Write  out  1  CACHE write enable.
- Waddr  out  ADDR_W  CACHE write address.
- Wdata  out  DATA_W  CACHE write data.
- Busy  out  1  load in progress.
- Done  out  1  load completed successfully (sticky).
- Error  out  1  load aborted (sticky).
- CpuHold  out  1  CPU reset request; high while in reset and until Done.

Behaviour:
- Reset (async): state IDLE. Write, InReady, Busy, Done and Error are 0. Waddr and Wdata are 0. CpuHold is 1. Word counter and index are 0.
- A Reset mid-load returns to IDLE immediately. CACHE contents already written are kept, since CACHE has no reset.
- States: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WR, DONE, ERR.
- IDLE:
  - InReady=0.
  - Start=1 → CNT_HI; Busy=1; Done and Error cleared; CpuHold=1.
- CNT_HI / CNT_LO: InReady=1. Receive the 16-bit word count N, high byte first.
- Count checks, applied after CNT_LO:
  - N==0 → DONE.
  - N > 2^ADDR_W − BASE_ADDR → ERR.
  - Otherwise → DAT_HI with index=0.
- DAT_HI: InReady=1. Latch the high byte.
- DAT_LO: InReady=1. Latch the low byte, then → WR.
- WR:
  - One cycle with InReady=0 and Write=1.
  - Waddr=BASE_ADDR+index; Wdata={hi,lo}.
  - index++. If index+1==N → DONE, else → DAT_HI.
- Write is registered and lasts exactly one cycle per word. Byte-to-write latency is 1 cycle after the low-byte transfer. Minimum throughput is 1 word per 3 cycles.
- DONE: Busy=0, Done=1, CpuHold=0.
- ERR: Busy=0, Error=1, CpuHold=1.
- From DONE or ERR, Start=1 → CNT_HI, i.e. a reload, with CpuHold reasserted the same edge.
- Start while Busy is ignored.
- InValid=0 in a receive state stalls indefinitely with no timeout.
- Bytes offered while InReady=0 are not consumed.
- Address arithmetic is modulo 2^ADDR_W. The count check guarantees no wrap.
- Write and Waddr outside WR: Write=0. Waddr and Wdata hold their last value.

Optional Feature:
- Macro: CACHE_LOADER_CHECKSUM_EN.
- With the macro defined:
  - A 16-bit running sum (mod 2^16) of all written words is kept.
  - After the last WR, states CK_HI and CK_LO receive a 2-byte checksum, high byte first.
  - Match → DONE; mismatch → ERR.
  - N==0 still expects a checksum, which must be 0x0000.
- Without the macro: after the last WR → DONE directly, and there is no checksum logic.

Decomposition:
- Shared package cache_loader_pkg:
  - State enum constants.
  - BYTES_PER_WORD=2.
  - Default ADDR_W and DATA_W values shared with CACHE.
- Natural sub-module: byte_assembler. It takes the hi/lo byte handshake and produces a word-valid pulse with a 16-bit word; the FSM, counters and checksum remain in cache_loader.

Test Plan:
1. Load of 3 words, BASE_ADDR=0: Reset, Start, bytes 00 03 12 34 AB CD 00 01.
   - Write pulses with Waddr/Wdata (0,0x1234), (1,0xABCD), (2,0x0001).
   - Then Done=1, CpuHold=0, Busy=0.
2. Host stalls: InValid toggling 1/0 every cycle during scenario 1 → identical writes. InReady never consumes a byte while in WR.
3. Boundary counts:
   - N=0 (bytes 00 00) → Done with no Write.
   - N=1024 with BASE_ADDR=0 → last Waddr=0x3FF.
   - N=1025 (bytes 04 01) → Error=1, CpuHold=1, no Write.
4. Reset mid-load: async Reset after the 2nd word is written → all outputs at reset values within the same cycle.
   - Then Start and a 1-word image 00 01 BE EF → Write (0,0xBEEF), Done.
5. Start pulsed during a load → ignored; the load completes normally. Start after Done → reload, and CpuHold rises on that edge.
6. With CACHE_LOADER_CHECKSUM_EN:
   - Scenario 1 data followed by checksum BE 02 (sum of 0x1234+0xABCD+0x0001) → Done.
   - Checksum BE 03 → Error=1, CpuHold=1.
